dsi_tx_csr_bank: RTL and testbench
==================================

// Module: dsi_tx_csr_bank
// PURPOSE
//  Avalon-MM control/status register bank for the DSI/CSI TX path, parametrised in lane count and interrupt sources.
//  Built-in slave FSM: no external MM manager. Drives assembler/lane/clock enables and D-PHY timing fields.
//  Latches timing fields from staging registers at frame boundaries, so a timing change never lands mid-frame.
// PARAMETERS
//  LANES_MAX   4            max data lanes; power of two, >=2; LNW = $clog2(LANES_MAX)
//  IRQ_NUM     8            interrupt sources, 1..16
//  VERSION     32'h0002_0000  value returned by ID register
// PORTS
//  clk                   in   1        clock
//  rst_n                 in   1        async reset, active low
//  avl_mm_addr           in   5        byte address, word aligned
//  avl_mm_read           in   1        read request
//  avl_mm_readdata       out  32       read data, valid when read && !waitrequest
//  avl_mm_response       out  2        00 OKAY, 10 SLVERR (unmapped address)
//  avl_mm_write          in   1        write request
//  avl_mm_writedata      in   32       write data
//  avl_mm_byteenable     in   4        byte lane enables
//  avl_mm_waitrequest    out  1        slave stall
//  irq                   out  1        registered |(ISR & IER)
//  irq_set               in   IRQ_NUM  one-cycle set pulses into ISR
//  status_in             in   16       live status, read-only in SR
//  frame_boundary        in   1        pulse; applies staged timing fields
//  packet_assembler_enable, lanes_enable, clk_out_enable  out 1 each   CR bits
//  lanes_number          out  LNW+1    CR.lanes_field + 1
//  soft_rst              out  1        one-cycle pulse on write of CR[31]=1
//  tlpx_timeout, hs_prepare_timeout, hs_exit_timeout, hs_go_timeout, hs_trail_timeout  out 8 each
// BEHAVIOUR
//  Slave FSM: IDLE -> ACK -> IDLE.
//   - In IDLE, read or write asserted: waitrequest=1, then go to ACK.
//   - In ACK: waitrequest=0 for exactly one cycle; register write commits, readdata/response valid; return to IDLE.
//   - Result: every access takes 2 cycles. Reset value of waitrequest is 1.
//   - read and write asserted together: handled as a write; readdata=0.
//   - Unmapped address: write dropped, readdata=0, response=10, still acked.
//  Byteenable: RW fields update only in enabled bytes. RW1C bits clear only in enabled bytes.
//  Map:
//   0x00 CR   [0]asm_en [1]lanes_en [2]clk_en [8+:LNW]lanes_field (reset LANES_MAX-1) [31]soft_rst (W1, reads 0)
//   0x04 ISR  [IRQ_NUM-1:0] RW1C. If a set pulse and a W1C land in the same cycle, set wins.
//   0x08 IER  [IRQ_NUM-1:0] RW, reset 0
//   0x0C TR1  [23:16]tlpx=8 [15:8]hs_prepare=15 [7:0]hs_exit=3 (staging)
//   0x10 TR2  [15:8]hs_go=30 [7:0]hs_trail=2 (staging)
//   0x14 SR   [15:0]status_in [16]shadow_pending (RO)
//   0x18 ID   VERSION (RO)
//  Reset values of outputs:
//   - all enables=0; lanes_number=LANES_MAX; soft_rst=0; irq=0
//   - timing outputs = staging reset values; readdata=0; response=00
//  irq: registered one cycle after the ISR/IER change. Read of ISR returns the pre-clear value.
//  lanes_number arithmetic: {1'b0,lanes_field}+1, never wraps.
//  Reset asserted mid-access: FSM returns to IDLE, pending access dropped, all fields to reset values.
// CONFIGURATION
//  DSI_TX_CSR_SHADOW_EN defined:
//   - TR1/TR2 writes go to staging and set shadow_pending.
//   - Outputs load staging on frame_boundary, or on the next cycle if lanes_enable=0; shadow_pending then clears.
//   - frame_boundary coincident with a TR write: the new value is applied and pending stays 0.
//  Not defined:
//   - Outputs equal staging, updating in the cycle after the ACK.
//   - shadow_pending reads 0; frame_boundary is ignored.
// TESTING
//  1. Reset, read all 7 addresses -> CR=0x0000_0300, TR1=0x0008_0F03, TR2=0x0000_1E02, ID=VERSION, each waitrequest low 1 cycle.
//  2. Write CR=0x0000_0107 with byteenable=4'b0001 -> enables=1, lanes_number stays 4; rewrite with 4'b0011 -> lanes_number=2.
//  3. Set IER=0x3, pulse irq_set[1] -> irq=1 two cycles later.
//     Then W1C ISR=0x2 while pulsing irq_set[1] in the same cycle -> ISR[1]=1, irq stays 1.
//  4. Read 0x1C -> response=10, readdata=0. Write 0x1C -> no register changes.
//  5. SHADOW_EN, lanes_en=1: write TR1=0x0010_2005 -> outputs unchanged, SR[16]=1.
//     Pulse frame_boundary -> tlpx=0x10, hs_prepare=0x20, hs_exit=0x05, SR[16]=0.
//  6. Write CR[31]=1 -> soft_rst high exactly 1 cycle, CR reads [31]=0. Assert rst_n mid-read -> waitrequest=1, fields reset.

Source files
------------

// File: rtl/dsi_tx_csr_bank.sv
// dsi_tx_csr_bank: Avalon-MM control/status registers for the DSI/CSI TX path (enables, IRQ, D-PHY timing).
// Build option DSI_TX_CSR_SHADOW_EN holds TR1/TR2 writes in staging until a frame boundary.
module dsi_tx_csr_bank #(
   parameter int          LANES_MAX = 4,
   parameter int          IRQ_NUM   = 8,
   parameter logic [31:0] VERSION   = 32'h0002_0000,
   localparam int         LNW       = $clog2(LANES_MAX)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4:0]         avl_mm_addr,
   input  logic               avl_mm_read,
   output logic [31:0]        avl_mm_readdata,
   output logic [1:0]         avl_mm_response,
   input  logic               avl_mm_write,
   input  logic [31:0]        avl_mm_writedata,
   input  logic [3:0]         avl_mm_byteenable,
   output logic               avl_mm_waitrequest,
   output logic               irq,
   input  logic [IRQ_NUM-1:0] irq_set,
   input  logic [15:0]        status_in,
   input  logic               frame_boundary,
   output logic               packet_assembler_enable,
   output logic               lanes_enable,
   output logic               clk_out_enable,
   output logic [LNW:0]       lanes_number,
   output logic               soft_rst,
   output logic [7:0]         tlpx_timeout,
   output logic [7:0]         hs_prepare_timeout,
   output logic [7:0]         hs_exit_timeout,
   output logic [7:0]         hs_go_timeout,
   output logic [7:0]         hs_trail_timeout
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   localparam logic [2:0] A_CR  = 3'd0;
   localparam logic [2:0] A_ISR = 3'd1;
   localparam logic [2:0] A_IER = 3'd2;
   localparam logic [2:0] A_TR1 = 3'd3;
   localparam logic [2:0] A_TR2 = 3'd4;
   localparam logic [2:0] A_SR  = 3'd5;
   localparam logic [2:0] A_ID  = 3'd6;

   state_t             state;
   logic [2:0]         addr_q;
   logic               wr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic               commit;
   logic [31:0]        wmask;
   logic [31:0]        rd_mux;
   logic               rd_mapped;
   logic [LNW-1:0]     lanes_field;
   logic [IRQ_NUM-1:0] isr;
   logic [IRQ_NUM-1:0] ier;
   logic [IRQ_NUM-1:0] isr_clr;
   logic [7:0]         tlpx_stg, hs_prepare_stg, hs_exit_stg, hs_go_stg, hs_trail_stg;
   logic [7:0]         tlpx_nxt, hs_prepare_nxt, hs_exit_nxt, hs_go_nxt, hs_trail_nxt;
   logic               shadow_pending;

   // Handshake: a transfer is requested by read or write and completes in the one cycle where
   // waitrequest is low; the master holds address/data/byteenable while waitrequest is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         avl_mm_waitrequest <= 1'b1;
         avl_mm_readdata    <= '0;
         avl_mm_response    <= 2'b00;
         addr_q             <= '0;
         wr_q               <= 1'b0;
         wdata_q            <= '0;
         be_q               <= '0;
      end else if (state == S_IDLE) begin
         if (avl_mm_read || avl_mm_write) begin
            state              <= S_ACK;
            avl_mm_waitrequest <= 1'b0;
            addr_q             <= avl_mm_addr[4:2];
            wr_q               <= avl_mm_write;
            wdata_q            <= avl_mm_writedata;
            be_q               <= avl_mm_byteenable;
            avl_mm_readdata    <= (avl_mm_write || !rd_mapped) ? 32'h0 : rd_mux;
            avl_mm_response    <= rd_mapped ? 2'b00 : 2'b10;
         end
      end else begin
         state              <= S_IDLE;
         avl_mm_waitrequest <= 1'b1;
         avl_mm_readdata    <= '0;
         avl_mm_response    <= 2'b00;
         wr_q               <= 1'b0;
      end
   end

   assign commit = (state == S_ACK) && wr_q;
   assign wmask  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

   always_comb begin
      rd_mux    = '0;
      rd_mapped = 1'b1;
      case (avl_mm_addr[4:2])
         A_CR:    rd_mux = 32'({lanes_field, 5'b0_0000, clk_out_enable, lanes_enable,
                                packet_assembler_enable});
         A_ISR:   rd_mux = 32'(isr);
         A_IER:   rd_mux = 32'(ier);
         A_TR1:   rd_mux = {8'h00, tlpx_stg, hs_prepare_stg, hs_exit_stg};
         A_TR2:   rd_mux = {16'h0000, hs_go_stg, hs_trail_stg};
         A_SR:    rd_mux = {15'h0000, shadow_pending, status_in};
         A_ID:    rd_mux = VERSION;
         default: rd_mapped = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packet_assembler_enable <= 1'b0;
         lanes_enable            <= 1'b0;
         clk_out_enable          <= 1'b0;
         lanes_field             <= LNW'(LANES_MAX - 1);
         soft_rst                <= 1'b0;
      end else begin
         soft_rst <= 1'b0;
         if (commit && addr_q == A_CR) begin
            if (be_q[0]) begin
               packet_assembler_enable <= wdata_q[0];
               lanes_enable            <= wdata_q[1];
               clk_out_enable          <= wdata_q[2];
            end
            if (be_q[1]) lanes_field <= wdata_q[8 +: LNW];
            if (be_q[3]) soft_rst    <= wdata_q[31];
         end
      end
   end

   // Zero-extended before the increment so the largest field maps to LANES_MAX.
   assign lanes_number = {1'b0, lanes_field} + (LNW + 1)'(1);

   // A set pulse is OR-ed after the clear, so it wins over a coincident W1C.
   assign isr_clr = (commit && addr_q == A_ISR) ? (wmask[IRQ_NUM-1:0] & wdata_q[IRQ_NUM-1:0]) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isr <= '0;
         ier <= '0;
         irq <= 1'b0;
      end else begin
         isr <= (isr & ~isr_clr) | irq_set;
         irq <= |(isr & ier);
         if (commit && addr_q == A_IER)
            ier <= (ier & ~wmask[IRQ_NUM-1:0]) | (wdata_q[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0]);
      end
   end

   always_comb begin
      tlpx_nxt       = tlpx_stg;
      hs_prepare_nxt = hs_prepare_stg;
      hs_exit_nxt    = hs_exit_stg;
      hs_go_nxt      = hs_go_stg;
      hs_trail_nxt   = hs_trail_stg;
      if (commit && addr_q == A_TR1) begin
         if (be_q[2]) tlpx_nxt       = wdata_q[23:16];
         if (be_q[1]) hs_prepare_nxt = wdata_q[15:8];
         if (be_q[0]) hs_exit_nxt    = wdata_q[7:0];
      end
      if (commit && addr_q == A_TR2) begin
         if (be_q[1]) hs_go_nxt    = wdata_q[15:8];
         if (be_q[0]) hs_trail_nxt = wdata_q[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tlpx_stg       <= 8'd8;
         hs_prepare_stg <= 8'd15;
         hs_exit_stg    <= 8'd3;
         hs_go_stg      <= 8'd30;
         hs_trail_stg   <= 8'd2;
      end else begin
         tlpx_stg       <= tlpx_nxt;
         hs_prepare_stg <= hs_prepare_nxt;
         hs_exit_stg    <= hs_exit_nxt;
         hs_go_stg      <= hs_go_nxt;
         hs_trail_stg   <= hs_trail_nxt;
      end
   end

`ifdef DSI_TX_CSR_SHADOW_EN
   logic tr_wr;
   assign tr_wr = commit && (addr_q == A_TR1 || addr_q == A_TR2);

   // With the lanes idle there is no frame to protect, so staging is applied a cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tlpx_timeout       <= 8'd8;
         hs_prepare_timeout <= 8'd15;
         hs_exit_timeout    <= 8'd3;
         hs_go_timeout      <= 8'd30;
         hs_trail_timeout   <= 8'd2;
         shadow_pending     <= 1'b0;
      end else if (frame_boundary) begin
         tlpx_timeout       <= tlpx_nxt;
         hs_prepare_timeout <= hs_prepare_nxt;
         hs_exit_timeout    <= hs_exit_nxt;
         hs_go_timeout      <= hs_go_nxt;
         hs_trail_timeout   <= hs_trail_nxt;
         shadow_pending     <= 1'b0;
      end else if (tr_wr) begin
         shadow_pending <= 1'b1;
      end else if (shadow_pending && !lanes_enable) begin
         tlpx_timeout       <= tlpx_stg;
         hs_prepare_timeout <= hs_prepare_stg;
         hs_exit_timeout    <= hs_exit_stg;
         hs_go_timeout      <= hs_go_stg;
         hs_trail_timeout   <= hs_trail_stg;
         shadow_pending     <= 1'b0;
      end
   end
`else
   assign tlpx_timeout       = tlpx_stg;
   assign hs_prepare_timeout = hs_prepare_stg;
   assign hs_exit_timeout    = hs_exit_stg;
   assign hs_go_timeout      = hs_go_stg;
   assign hs_trail_timeout   = hs_trail_stg;
   assign shadow_pending     = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{avl_mm_addr[1:0], wdata_q, wmask, frame_boundary};

endmodule

// File: tb/tb_dsi_tx_csr_bank.sv
// Directed bench for dsi_tx_csr_bank: Avalon-MM accesses checked against an expected-read queue.
// Follows DSI_TX_CSR_SHADOW_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dsi_tx_csr_bank;
   localparam int          LANES_MAX = 4;
   localparam int          IRQ_NUM   = 8;
   localparam int          LNW       = 2;
   localparam logic [31:0] VERSION   = 32'h0002_0000;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [4:0]         avl_mm_addr;
   logic               avl_mm_read;
   logic [31:0]        avl_mm_readdata;
   logic [1:0]         avl_mm_response;
   logic               avl_mm_write;
   logic [31:0]        avl_mm_writedata;
   logic [3:0]         avl_mm_byteenable;
   logic               avl_mm_waitrequest;
   logic               irq;
   logic [IRQ_NUM-1:0] irq_set;
   logic [15:0]        status_in;
   logic               frame_boundary;
   logic               packet_assembler_enable, lanes_enable, clk_out_enable;
   logic [LNW:0]       lanes_number;
   logic               soft_rst;
   logic [7:0]         tlpx_timeout, hs_prepare_timeout, hs_exit_timeout, hs_go_timeout, hs_trail_timeout;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [1:0]  resp_q[$];
   logic [15:0] status_val;

   always #5 clk = ~clk;

   dsi_tx_csr_bank #(.LANES_MAX(LANES_MAX), .IRQ_NUM(IRQ_NUM), .VERSION(VERSION)) dut (
      .clk(clk), .rst_n(rst_n),
      .avl_mm_addr(avl_mm_addr), .avl_mm_read(avl_mm_read), .avl_mm_readdata(avl_mm_readdata),
      .avl_mm_response(avl_mm_response), .avl_mm_write(avl_mm_write),
      .avl_mm_writedata(avl_mm_writedata), .avl_mm_byteenable(avl_mm_byteenable),
      .avl_mm_waitrequest(avl_mm_waitrequest), .irq(irq), .irq_set(irq_set),
      .status_in(status_in), .frame_boundary(frame_boundary),
      .packet_assembler_enable(packet_assembler_enable), .lanes_enable(lanes_enable),
      .clk_out_enable(clk_out_enable), .lanes_number(lanes_number), .soft_rst(soft_rst),
      .tlpx_timeout(tlpx_timeout), .hs_prepare_timeout(hs_prepare_timeout),
      .hs_exit_timeout(hs_exit_timeout), .hs_go_timeout(hs_go_timeout),
      .hs_trail_timeout(hs_trail_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One access; the expected read data and response are popped when the ack cycle is seen.
   task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [IRQ_NUM-1:0] set_in_ack, input string tag);
      int          cyc;
      logic [31:0] e_data;
      logic [1:0]  e_resp;
      avl_mm_addr       = addr;
      avl_mm_read       = rd;
      avl_mm_write      = wr;
      avl_mm_writedata  = wdata;
      avl_mm_byteenable = be;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (avl_mm_waitrequest && cyc < 8);
      chk({tag, " wait_cycles"}, 32'(cyc), 32'd1);
      irq_set = set_in_ack;
      e_data  = exp_q.pop_front();
      e_resp  = resp_q.pop_front();
      chk({tag, " readdata"}, avl_mm_readdata, e_data);
      chk({tag, " response"}, 32'(avl_mm_response), 32'(e_resp));
      step();
      avl_mm_read  = 1'b0;
      avl_mm_write = 1'b0;
      irq_set      = '0;
      chk({tag, " waitreq_back_high"}, 32'(avl_mm_waitrequest), 32'd1);
   endtask

   task automatic rd(input logic [4:0] addr, input logic [31:0] exp_data,
                     input logic [1:0] exp_resp, input string tag);
      exp_q.push_back(exp_data);
      resp_q.push_back(exp_resp);
      bus_xfer(1'b1, 1'b0, addr, 32'h0, 4'hF, '0, tag);
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be,
                     input logic [1:0] exp_resp, input logic [IRQ_NUM-1:0] set_in_ack,
                     input string tag);
      exp_q.push_back(32'h0);
      resp_q.push_back(exp_resp);
      bus_xfer(1'b0, 1'b1, addr, data, be, set_in_ack, tag);
   endtask

   task automatic chk_reset_fields(input string tag);
      chk({tag, " enables"}, 32'({packet_assembler_enable, lanes_enable, clk_out_enable}), 32'd0);
      chk({tag, " lanes_number"}, 32'(lanes_number), 32'd4);
      chk({tag, " soft_rst"}, 32'(soft_rst), 32'd0);
      chk({tag, " irq"}, 32'(irq), 32'd0);
      chk({tag, " tr1_out"}, {8'h0, tlpx_timeout, hs_prepare_timeout, hs_exit_timeout}, 32'h0008_0F03);
      chk({tag, " tr2_out"}, {16'h0, hs_go_timeout, hs_trail_timeout}, 32'h0000_1E02);
   endtask

   initial begin
      avl_mm_addr = '0; avl_mm_read = 1'b0; avl_mm_write = 1'b0;
      avl_mm_writedata = '0; avl_mm_byteenable = '0;
      irq_set = '0; frame_boundary = 1'b0;
      status_val = 16'($urandom_range(0, 16'hFFFF));
      status_in  = status_val;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Reset state and full register map
      chk("rst waitrequest", 32'(avl_mm_waitrequest), 32'd1);
      chk("rst readdata", avl_mm_readdata, 32'h0);
      chk("rst response", 32'(avl_mm_response), 32'd0);
      chk_reset_fields("rst");
      rd(5'h00, 32'h0000_0300, 2'b00, "rd CR");
      rd(5'h04, 32'h0, 2'b00, "rd ISR");
      rd(5'h08, 32'h0, 2'b00, "rd IER");
      rd(5'h0C, 32'h0008_0F03, 2'b00, "rd TR1");
      rd(5'h10, 32'h0000_1E02, 2'b00, "rd TR2");
      rd(5'h14, {16'h0, status_val}, 2'b00, "rd SR");
      rd(5'h18, VERSION, 2'b00, "rd ID");

      // CR byte enables and lanes_number arithmetic
      wr(5'h00, 32'h0000_0107, 4'b0001, 2'b00, '0, "wr CR be1");
      chk("CR be1 enables", 32'({packet_assembler_enable, lanes_enable, clk_out_enable}), 32'd7);
      chk("CR be1 lanes", 32'(lanes_number), 32'd4);
      wr(5'h00, 32'h0000_0107, 4'b0011, 2'b00, '0, "wr CR be3");
      chk("CR be3 lanes", 32'(lanes_number), 32'd2);
      rd(5'h00, 32'h0000_0107, 2'b00, "rd CR 107");
      wr(5'h00, 32'h0000_0000, 4'b0010, 2'b00, '0, "wr CR lanes0");
      chk("CR lanes0", 32'(lanes_number), 32'd1);
      chk("CR lanes0 enables", 32'({packet_assembler_enable, lanes_enable, clk_out_enable}), 32'd7);
      wr(5'h00, 32'h0000_0307, 4'b0010, 2'b00, '0, "wr CR lanes3");
      chk("CR lanes3 no wrap", 32'(lanes_number), 32'd4);

      // Interrupts
      wr(5'h08, 32'h0000_0003, 4'b0001, 2'b00, '0, "wr IER");
      irq_set = 8'h02;
      step();
      irq_set = '0;
      chk("irq +1 cycle", 32'(irq), 32'd0);
      step();
      chk("irq +2 cycles", 32'(irq), 32'd1);
      rd(5'h04, 32'h0000_0002, 2'b00, "rd ISR set");
      wr(5'h04, 32'h0000_0002, 4'b0001, 2'b00, 8'h02, "w1c with set");
      chk("irq set wins", 32'(irq), 32'd1);
      rd(5'h04, 32'h0000_0002, 2'b00, "rd ISR set wins");
      chk("irq still set", 32'(irq), 32'd1);
      wr(5'h04, 32'h0000_0002, 4'b0000, 2'b00, '0, "w1c no be");
      rd(5'h04, 32'h0000_0002, 2'b00, "rd ISR no be");
      wr(5'h04, 32'h0000_0002, 4'b0001, 2'b00, '0, "w1c");
      chk("irq lags clear", 32'(irq), 32'd1);
      step();
      chk("irq cleared", 32'(irq), 32'd0);
      rd(5'h04, 32'h0, 2'b00, "rd ISR cleared");
      irq_set = 8'h20;
      step();
      irq_set = '0;
      step();
      chk("irq masked", 32'(irq), 32'd0);
      rd(5'h04, 32'h0000_0020, 2'b00, "rd ISR masked");
      wr(5'h04, 32'h0000_0020, 4'b0001, 2'b00, '0, "w1c masked");

      // Read and write together act as a write
      exp_q.push_back(32'h0);
      resp_q.push_back(2'b00);
      bus_xfer(1'b1, 1'b1, 5'h08, 32'h0000_0005, 4'hF, '0, "rd+wr IER");
      rd(5'h08, 32'h0000_0005, 2'b00, "rd IER 5");

      // Unmapped address
      rd(5'h1C, 32'h0, 2'b10, "rd unmapped");
      wr(5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, '0, "wr unmapped");
      rd(5'h00, 32'h0000_0307, 2'b00, "rd CR after unmapped");
      rd(5'h08, 32'h0000_0005, 2'b00, "rd IER after unmapped");
      rd(5'h0C, 32'h0008_0F03, 2'b00, "rd TR1 after unmapped");

      // Timing registers
      wr(5'h0C, 32'h0010_2005, 4'hF, 2'b00, '0, "wr TR1");
`ifdef DSI_TX_CSR_SHADOW_EN
      chk("TR1 held", {8'h0, tlpx_timeout, hs_prepare_timeout, hs_exit_timeout}, 32'h0008_0F03);
      rd(5'h14, {15'h0, 1'b1, status_val}, 2'b00, "rd SR pending");
      frame_boundary = 1'b1;
      step();
      frame_boundary = 1'b0;
      chk("TR1 applied", {8'h0, tlpx_timeout, hs_prepare_timeout, hs_exit_timeout}, 32'h0010_2005);
      rd(5'h14, {16'h0, status_val}, 2'b00, "rd SR applied");
`else
      chk("TR1 direct", {8'h0, tlpx_timeout, hs_prepare_timeout, hs_exit_timeout}, 32'h0010_2005);
      rd(5'h14, {16'h0, status_val}, 2'b00, "rd SR no pending");
      frame_boundary = 1'b1;
      step();
      frame_boundary = 1'b0;
      chk("TR1 fb ignored", {8'h0, tlpx_timeout, hs_prepare_timeout, hs_exit_timeout}, 32'h0010_2005);
`endif
      rd(5'h0C, 32'h0010_2005, 2'b00, "rd TR1 new");
      wr(5'h10, 32'h0000_5566, 4'b0001, 2'b00, '0, "wr TR2 be1");
      rd(5'h10, 32'h0000_1E66, 2'b00, "rd TR2 be1");
`ifdef DSI_TX_CSR_SHADOW_EN
      frame_boundary = 1'b1;
      step();
      frame_boundary = 1'b0;
`endif
      chk("TR2 out be1", {16'h0, hs_go_timeout, hs_trail_timeout}, 32'h0000_1E66);

      // Soft reset pulse
      wr(5'h00, 32'h8000_0000, 4'b1000, 2'b00, '0, "wr soft_rst");
      chk("soft_rst high", 32'(soft_rst), 32'd1);
      step();
      chk("soft_rst one cycle", 32'(soft_rst), 32'd0);
      rd(5'h00, 32'h0000_0307, 2'b00, "rd CR after soft_rst");

      // Reset in the middle of a read
      avl_mm_addr = 5'h0C;
      avl_mm_read = 1'b1;
      step();
      chk("mid-read ack", 32'(avl_mm_waitrequest), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid-read rst waitrequest", 32'(avl_mm_waitrequest), 32'd1);
      chk_reset_fields("mid-read rst");
      avl_mm_read = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      rd(5'h00, 32'h0000_0300, 2'b00, "rd CR after rst");
      rd(5'h08, 32'h0, 2'b00, "rd IER after rst");
      rd(5'h0C, 32'h0008_0F03, 2'b00, "rd TR1 after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
